// File: rtl/obstacle_mover.sv
// obstacle_mover: steps one obstacle sprite down its lane on each speed tick.
// Every erase and redraw goes through a req/ack handshake with the VGA plotter.
// Passed pulses when the sprite leaves the bottom of the play field.
module obstacle_mover #(
  parameter int Y_W     = 7,
  parameter int X_W     = 8,
  parameter int Y_START = 0,
  parameter int Y_LIMIT = 120,
  parameter int STEP    = 4
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           Start,
  input  logic [X_W-1:0] LaneX,
  input  logic           Tick,
  input  logic           Halt,
  input  logic           DrawAck,
  output logic           DrawReq,
  output logic           Erase,
  output logic [X_W-1:0] PosX,
  output logic [Y_W-1:0] PosY,
  output logic           Active,
  output logic           Passed
);

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    WAIT,
    ERASE,
    MOVE
  } state_t;

  state_t state;
  state_t state_next;

  logic pending;
  logic pending_next;
  logic load_spawn;
  logic load_step;
  logic passed_next;

  // One extra bit on the candidate row so a step past the bottom cannot wrap.
  logic [Y_W:0] y_candidate;
  logic         off_screen;

  assign y_candidate = {1'b0, PosY} + (Y_W+1)'(STEP);
  assign off_screen  = (y_candidate >= (Y_W+1)'(Y_LIMIT));

  // State register, remembered tick and registered handshake/status outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      pending <= 1'b0;
      DrawReq <= 1'b0;
      Erase   <= 1'b0;
      Active  <= 1'b0;
      Passed  <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      DrawReq <= (state_next == DRAW) || (state_next == ERASE);
      Erase   <= (state_next == ERASE);
      Active  <= (state_next != IDLE);
      Passed  <= passed_next;
    end
  end

  // Next-state logic; ticks arriving mid-handshake are remembered once.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    load_spawn   = 1'b0;
    load_step    = 1'b0;
    passed_next  = 1'b0;
    case (state)
      IDLE: begin
        pending_next = 1'b0;
        if (Start) begin
          load_spawn = 1'b1;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (Tick) pending_next = 1'b1;
        if (DrawAck) state_next = WAIT;
      end
      WAIT: begin
        if (Halt) begin
          pending_next = 1'b0;
        end else if (Tick || pending) begin
          pending_next = 1'b0;
          state_next   = ERASE;
        end
      end
      ERASE: begin
        if (Tick) pending_next = 1'b1;
        if (DrawAck) state_next = MOVE;
      end
      MOVE: begin
        if (Tick) pending_next = 1'b1;
        if (off_screen) begin
          passed_next = 1'b1;
          state_next  = IDLE;
        end else begin
          load_step  = 1'b1;
          state_next = DRAW;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sprite position: loaded on spawn, advanced only when leaving MOVE on screen.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      PosX <= '0;
      PosY <= '0;
    end else if (load_spawn) begin
      PosX <= LaneX;
      PosY <= Y_W'(Y_START);
    end else if (load_step) begin
      PosY <= y_candidate[Y_W-1:0];
    end
  end

endmodule

// File: doc/obstacle_mover.md
Name: obstacle_mover

Overview:
- Consumer of the one-cycle speed enable pulses produced by the half/quarter/eighth-second tick generators.
- Each tick steps one obstacle sprite down its lane by STEP rows.
- Handshakes every erase and redraw with the VGA plotter through a req/ack pair.
- Emits Passed when the obstacle leaves the screen, so the game FSM can score and respawn it.

Parameters:
- Y_W, 7, width of the row coordinate.
- X_W, 8, width of the column coordinate.
- Y_START, 0, row loaded on Start.
- Y_LIMIT, 120, first row treated as off-screen.
- STEP, 4, rows advanced per tick.

Ports:
- Clock  input  1  system clock (CLOCK_50 domain).
- Resetn  input  1  asynchronous, active-low reset.
- Start  input  1  single-cycle pulse: spawn the obstacle at (LaneX, Y_START).
- LaneX  input  X_W  column of the lane, sampled only when Start is accepted.
- Tick  input  1  single-cycle speed enable (HSecEn/QSecEn/ESecEn, selected upstream).
- Halt  input  1  level; freezes movement (collision / pause).
- DrawAck  input  1  plotter has finished the current rectangle.
- DrawReq  output  1  request to the plotter.
- Erase  output  1  1 = paint background colour, 0 = paint obstacle colour.
- PosX  output  X_W  current column.
- PosY  output  Y_W  current row.
- Active  output  1  obstacle is on screen (state != IDLE).
- Passed  output  1  single-cycle pulse when the obstacle exits at Y_LIMIT.

Behaviour:
- Reset (asynchronous, Resetn=0):
  - State goes to IDLE; the pending-tick flag clears.
  - All outputs go to 0: DrawReq, Erase, PosX, PosY, Active, Passed.
  - This applies mid-handshake too: DrawReq drops immediately, and the plotter must tolerate an abandoned request.
- States: IDLE, DRAW, WAIT, ERASE, MOVE. All transitions occur on posedge Clock.
- IDLE:
  - On Start=1: PosX<=LaneX, PosY<=Y_START, go to DRAW. DrawReq=1 and Erase=0 in the next cycle.
  - Tick and DrawAck are ignored in IDLE.
- DRAW:
  - DrawReq=1, Erase=0.
  - On DrawAck=1, go to WAIT; DrawReq is 0 in the following cycle.
- WAIT:
  - DrawReq=0.
  - If Halt=0 and (Tick=1 or pending=1): go to ERASE and clear pending.
  - If Halt=1: stay in WAIT; clear pending and discard any Tick.
- ERASE:
  - DrawReq=1, Erase=1.
  - On DrawAck=1, go to MOVE.
- MOVE (exactly one cycle, DrawReq=0):
  - Compute next = PosY + STEP in Y_W+1 bits, so there is no wrap-around.
  - If next >= Y_LIMIT: go to IDLE, pulse Passed=1 for that one cycle, Active=0. PosY keeps its last on-screen value.
  - Otherwise: PosY<=next[Y_W-1:0], go to DRAW.
- Handshake rules:
  - While DrawReq=1, PosX, PosY and Erase are held stable.
  - DrawAck is sampled only while DrawReq=1; an ack seen with DrawReq=0 is ignored.
  - An ack in the same cycle the request first rises is legal: single-cycle request.
- Tick during DRAW, ERASE or MOVE sets pending=1. Pending saturates at one, so extra ticks are dropped.
- Halt during DRAW or ERASE does not abort the handshake. It takes effect on arrival in WAIT.
- Start while Active=1 is ignored. There is no respawn until Passed has fired.
- Start and Tick in the same IDLE cycle: Start is accepted, the Tick is dropped.
- Latency:
  - Start to first DrawReq: 1 cycle.
  - Tick in WAIT to DrawReq: 1 cycle.
  - Ack in ERASE to redraw DrawReq: 2 cycles (through MOVE).
- Passed and Active are registered outputs. Active=1 exactly while state != IDLE.

Test Plan:
- Reset/spawn: Resetn=0 then 1, Start with LaneX=40 -> one cycle later DrawReq=1, Erase=0, PosX=40, PosY=0, Active=1; an immediate ack moves to WAIT with DrawReq=0.
- Step: in WAIT, pulse Tick -> ERASE at PosY=0 (Erase=1); ack -> MOVE -> DRAW at PosY=4. Three more tick/ack rounds -> PosY=16.
- Exit boundary: run to PosY=116, then Tick plus ack for the erase -> Passed=1 for exactly one cycle, Active=0, no further DrawReq. Also check Y_LIMIT=121, STEP=4: from PosY=116, next=120 stays on screen and is drawn.
- Pending tick: assert Tick twice while in DRAW with DrawAck held 0 for 10 cycles, then ack -> exactly one ERASE on WAIT entry, no second step without a new Tick.
- Halt: Halt=1 in WAIT with 5 Tick pulses -> PosY unchanged and no DrawReq; Halt=0 then one Tick -> a single step of 4.
- Reset mid-handshake: Resetn=0 while DrawReq=1 in ERASE -> DrawReq, Active, PosY=0 without waiting for a clock edge; a Start after release spawns normally.
